// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle datapath and its controller.
// slave = controller side (takes instruction fields, drives controls); master = datapath side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       illegal;
    logic [3:0] state_o;

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o
    );
    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I-subset multicycle controller: Moore main FSM plus ALU and immediate decoders.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR   = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECUTER = 4'd6,  ALUWB   = 4'd7,
        EXECUTEI = 4'd8,  JAL     = 4'd9,  BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t     state, state_nx, dec_st;
    logic [1:0] alu_op;
    logic       pc_update, branch;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:    state_nx = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECUTER;
                    OP_I:         state_nx = EXECUTEI;
                    OP_JAL:       state_nx = JAL;
                    OP_BEQ:       state_nx = BEQ;
                    default:      state_nx = FETCH;
                endcase
            end
            MEMADR:   state_nx = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nx = MEMWB;
            EXECUTER, EXECUTEI, JAL: state_nx = ALUWB;
            default:  state_nx = FETCH;
        endcase
    end

    // During reset the outputs decode as FETCH, then write enables are masked below.
    assign dec_st = reset ? FETCH : state;

    always_comb begin
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.illegal   = 1'b0;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        case (dec_st)
            FETCH: begin
                bus.IRWrite = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10; pc_update = 1'b1;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01;
                bus.illegal = !(bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
            end
            MEMADR:   begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB:    begin bus.ResultSrc = 2'b01; bus.RegWrite = 1'b1; end
            MEMWRITE: begin bus.AdrSrc = 1'b1; bus.MemWrite = 1'b1; end
            EXECUTER: begin bus.ALUSrcA = 2'b10; alu_op = 2'b10; end
            EXECUTEI: begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; alu_op = 2'b10; end
            ALUWB:    bus.RegWrite = 1'b1;
            JAL:      begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; pc_update = 1'b1; end
            BEQ:      begin bus.ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
            default:  ;
        endcase
        bus.PCWrite = pc_update | (branch & bus.Zero);
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.illegal  = 1'b0;
        end
    end

    always_comb begin
        bus.ALUControl = 3'b000;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.state_o = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Random instruction stream against a per-instruction path/control table model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] aluc;
    } ctl_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    // Whole-instruction state walk, by instruction class.
    function automatic void path_of(input logic [6:0] o, output int p[$]);
        case (o)
            7'b0000011: p = '{0, 1, 2, 3, 4};
            7'b0100011: p = '{0, 1, 2, 5};
            7'b0110011: p = '{0, 1, 6, 7};
            7'b0010011: p = '{0, 1, 8, 7};
            7'b1101111: p = '{0, 1, 9, 7};
            7'b1100011: p = '{0, 1, 10};
            default:    p = '{0, 1};
        endcase
    endfunction

    function automatic logic [2:0] aluc_of(input int aop, input logic [2:0] f3,
                                           input logic o5, input logic f7);
        if (aop == 0) return 3'd0;
        if (aop == 1) return 3'd1;
        if (f3 == 3'b000) return (o5 && f7) ? 3'd1 : 3'd0;
        if (f3 == 3'b010) return 3'd5;
        if (f3 == 3'b110) return 3'd3;
        if (f3 == 3'b111) return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'd1;
        if (o == 7'b1100011) return 2'd2;
        if (o == 7'b1101111) return 2'd3;
        return 2'd0;
    endfunction

    function automatic ctl_t exp_ctl(input int st, input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z);
        ctl_t c;
        int   aop;
        bit   pcu, br;
        c = '0; aop = 0; pcu = 0; br = 0;
        case (st)
            0:  begin c.irw = 1; c.sb = 2; c.res = 2; pcu = 1; end
            1:  begin c.sa = 1; c.sb = 1; c.ill = !is_legal(o); end
            2:  begin c.sa = 2; c.sb = 1; end
            3:  c.adr = 1;
            4:  begin c.res = 1; c.rw = 1; end
            5:  begin c.adr = 1; c.mw = 1; end
            6:  begin c.sa = 2; aop = 2; end
            7:  c.rw = 1;
            8:  begin c.sa = 2; c.sb = 1; aop = 2; end
            9:  begin c.sa = 1; c.sb = 2; pcu = 1; end
            10: begin c.sa = 2; aop = 1; br = 1; end
            default: ;
        endcase
        c.pcw  = pcu || (br && z);
        c.aluc = aluc_of(aop, f3, o[5], f7);
        c.imm  = imm_of(o);
        return c;
    endfunction

    function automatic ctl_t obs_ctl();
        ctl_t c;
        c.pcw = bus.PCWrite;  c.adr = bus.AdrSrc;   c.mw = bus.MemWrite;
        c.irw = bus.IRWrite;  c.rw  = bus.RegWrite; c.ill = bus.illegal;
        c.res = bus.ResultSrc; c.sa = bus.ALUSrcA;  c.sb = bus.ALUSrcB;
        c.imm = bus.ImmSrc;   c.aluc = bus.ALUControl;
        return c;
    endfunction

    function automatic ctl_t exp_rst(input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z);
        ctl_t c;
        c = exp_ctl(0, o, f3, f7, z);
        c.pcw = 0; c.irw = 0; c.mw = 0; c.rw = 0; c.ill = 0;
        return c;
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    endtask

    // Runs one instruction from FETCH; ncyc limits how many cycles are stepped (-1 = whole path).
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int ncyc);
        int p[$];
        int n;
        drive(o, f3, f7, z);
        path_of(o, p);
        n = (ncyc < 0 || ncyc > p.size()) ? p.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_state"}, 32'(bus.state_o), 32'(p[i]));
            check({tag, "_ctl"}, 32'(obs_ctl()), 32'(exp_ctl(p[i], o, f3, f7, z)));
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

    initial begin
        logic [6:0] o;
        drive(7'b0000011, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_ctl", 32'(obs_ctl()), 32'(exp_rst(7'b0000011, 3'b000, 1'b0, 1'b0)));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b1, -1);
        run_instr("sw",     7'b0100011, 3'b010, 1'b1, 1'b0, -1);
        run_instr("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("add",    7'b0110011, 3'b000, 1'b0, 1'b1, -1);
        run_instr("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        run_instr("addi_b", 7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run_instr("beq_n",  7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run_instr("jal",    7'b1101111, 3'b111, 1'b1, 1'b1, -1);
        run_instr("ill",    7'b0000000, 3'b000, 1'b0, 1'b0, -1);

        // Reset asserted with the FSM sitting in MEMREAD.
        run_instr("lw_abort", 7'b0000011, 3'b000, 1'b0, 1'b1, 3);
        @(negedge clk);
        check("abort_pre_state", 32'(bus.state_o), 32'd3);
        reset = 1'b1;
        #1;
        check("abort_rst_ctl", 32'(obs_ctl()), 32'(exp_rst(7'b0000011, 3'b000, 1'b0, 1'b1)));
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_state", 32'(bus.state_o), 32'd0);
            check("abort_ctl", 32'(obs_ctl()), 32'(exp_rst(7'b0000011, 3'b000, 1'b0, 1'b1)));
        end
        reset = 1'b0;
        run_instr("post_rst", 7'b0110011, 3'b110, 1'b0, 1'b0, -1);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 6) == 0) begin
                do o = 7'($urandom); while (is_legal(o));
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            run_instr("rnd", o, 3'($urandom), 1'($urandom), 1'($urandom), -1);
        end
        @(negedge clk);
        check("end_state", 32'(bus.state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
